// File: rtl/coin_pulse_gen.sv
// Coin acceptor front end: synchronizes and debounces three coin sensors, then
// issues one clean, mutually exclusive N/D/Q pulse per accepted coin.
module coin_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned HOLDOFF_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic coin_q_raw,
    input  logic enable,
    output logic N,
    output logic D,
    output logic Q,
    output logic reject,
    output logic busy
);

    localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned HW  = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLDOFF_CYCLES);

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    // Bit 0 nickel, bit 1 dime, bit 2 quarter throughout.
    logic [2:0]          raw;
    logic [2:0]          sync1_q;
    logic [2:0]          sync2_q;
    logic [2:0]          stable_q;
    logic [2:0]          stable_d;
    logic [2:0]          stable_dly_q;
    logic [2:0][DBW-1:0] db_cnt_q;
    logic [2:0][DBW-1:0] db_cnt_d;
    logic [2:0]          ev;
    logic                ev_any;
    logic                ev_single;
    state_e              state_q;
    state_e              state_d;
    logic [HW-1:0]       hold_q;
    logic [HW-1:0]       hold_d;
    logic [2:0]          pulse_q;
    logic [2:0]          pulse_d;
    logic                reject_q;
    logic                reject_d;

    assign raw = {coin_q_raw, coin_d_raw, coin_n_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            db_cnt_q     <= '0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end

    assign ev        = stable_q & ~stable_dly_q;
    assign ev_any    = |ev;
    assign ev_single = $onehot(ev);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            pulse_q  <= '0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            pulse_q  <= pulse_d;
            reject_q <= reject_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && ev_single && (HOLDOFF_CYCLES != 0)) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
            ST_HOLD: begin
                hold_d = hold_q - HW'(1);
                if (hold_q == HW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_comb begin
        pulse_d  = '0;
        reject_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && ev_single) begin
                    pulse_d = ev;
                end else if (ev_any) begin
                    reject_d = 1'b1;
                end
            end
            ST_HOLD: reject_d = ev_any;
            default: reject_d = 1'b0;
        endcase
    end

    assign N      = pulse_q[0];
    assign D      = pulse_q[1];
    assign Q      = pulse_q[2];
    assign reject = reject_q;
    assign busy   = (state_q == ST_HOLD);

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Bench for coin_pulse_gen: directed vector table, hand-written reset/bounce
// sequences and random sensor activity against a behavioural model.
module tb_coin_pulse_gen;

    localparam int unsigned DBC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rn    = 1'b0;
    logic rd    = 1'b0;
    logic rq    = 1'b0;
    logic en    = 1'b0;
    logic n1, d1, q1, rj1, b1;
    logic n3, d3, q3, rj3, b3;

    always #5 clk = ~clk;

    coin_pulse_gen #(.DEBOUNCE_CYCLES(DBC), .HOLDOFF_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .coin_n_raw(rn), .coin_d_raw(rd), .coin_q_raw(rq),
        .enable(en), .N(n1), .D(d1), .Q(q1), .reject(rj1), .busy(b1)
    );

    coin_pulse_gen #(.DEBOUNCE_CYCLES(DBC), .HOLDOFF_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .coin_n_raw(rn), .coin_d_raw(rd), .coin_q_raw(rq),
        .enable(en), .N(n3), .D(d3), .Q(q3), .reject(rj3), .busy(b3)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural reference model ----------------
    // A line's debounced level flips once the last DBC synchronized samples
    // (raw seen two clocks earlier) all disagree with it; a coin is a level
    // that rose on the previous clock.
    bit [2:0]    mh[$];
    bit [2:0]    m_stab;
    bit [2:0]    m_prev;
    int unsigned m_hold[2];
    bit [4:0]    m_out[2];          // {busy, reject, Q, D, N}

    function automatic int unsigned hold_of(input int unsigned i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        mh.delete();
        for (int unsigned j = 0; j < DBC + 2; j++) mh.push_back(3'b000);
        m_stab = '0;
        m_prev = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            m_hold[i] = 0;
            m_out[i]  = '0;
        end
    endtask

    task automatic model_step();
        bit [2:0]    nst;
        bit [2:0]    evs;
        bit          all_diff;
        int unsigned cnt;
        mh.push_back({rq, rd, rn});
        if (mh.size() > DBC + 2) void'(mh.pop_front());
        nst = m_stab;
        for (int unsigned l = 0; l < 3; l++) begin
            all_diff = 1'b1;
            for (int unsigned j = 0; j < DBC; j++)
                if (mh[j][l] == m_stab[l]) all_diff = 1'b0;
            if (all_diff) nst[l] = ~m_stab[l];
        end
        evs    = m_stab & ~m_prev;
        m_prev = m_stab;
        m_stab = nst;
        cnt    = $countones(evs);
        for (int unsigned i = 0; i < 2; i++) begin
            m_out[i] = '0;
            if (m_hold[i] > 0) begin
                if (cnt > 0) m_out[i][3] = 1'b1;
                m_hold[i]--;
            end else if (cnt == 1 && en) begin
                m_out[i][2:0] = evs;
                m_hold[i]     = hold_of(i);
            end else if (cnt > 0) begin
                m_out[i][3] = 1'b1;
            end
            m_out[i][4] = (m_hold[i] > 0);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("model_dut1", {b1, rj1, q1, d1, n1}, m_out[0]);
        check("model_dut3", {b3, rj3, q3, d3, n3}, m_out[1]);
    end

    // ---------------- pulse recording ----------------
    int unsigned rec_first[2][4];
    int unsigned rec_cnt[2][4];
    int unsigned rec_busy[2];

    task automatic clear_rec();
        for (int unsigned i = 0; i < 2; i++) begin
            rec_busy[i] = 0;
            for (int unsigned k = 0; k < 4; k++) begin
                rec_first[i][k] = 0;
                rec_cnt[i][k]   = 0;
            end
        end
    endtask

    task automatic sample_rec(input int unsigned e);
        bit [4:0] o[2];
        o[0] = {b1, rj1, q1, d1, n1};
        o[1] = {b3, rj3, q3, d3, n3};
        for (int unsigned i = 0; i < 2; i++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (o[i][k]) begin
                    if (rec_cnt[i][k] == 0) rec_first[i][k] = e;
                    rec_cnt[i][k]++;
                end
            end
            if (o[i][4]) rec_busy[i]++;
        end
    endtask

    function automatic string out_name(input int unsigned k);
        case (k)
            0: return "N";
            1: return "D";
            2: return "Q";
            default: return "reject";
        endcase
    endfunction

    task automatic expect_out(input string tag, input int unsigned i, input int unsigned k,
                              input int unsigned exp_edge);
        string nm;
        nm = $sformatf("%s_%s_dut%0d", tag, out_name(k), (i == 0) ? 1 : 3);
        if (exp_edge == 0) begin
            check({nm, "_count"}, rec_cnt[i][k], 0);
        end else begin
            check({nm, "_count"}, rec_cnt[i][k], 1);
            check({nm, "_edge"}, rec_first[i][k], exp_edge);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int unsigned sn, ln, sd, ld, sq, lq;   // first edge sampling 1, edges held
        bit          en;
        int unsigned e1[4];                    // expected pulse edge N/D/Q/reject, 0 = none
        int unsigned bz1;
        int unsigned e3[4];
        int unsigned bz3;
    } vec_t;

    vec_t tbl[10];

    function automatic bit line_on(input int unsigned s, input int unsigned l, input int unsigned e);
        return (l > 0) && (e >= s) && (e < s + l);
    endfunction

    task automatic drive_vec(input vec_t v, input int unsigned e);
        rn = line_on(v.sn, v.ln, e);
        rd = line_on(v.sd, v.ld, e);
        rq = line_on(v.sq, v.lq, e);
    endtask

    task automatic run_vec(input int unsigned idx, input vec_t v);
        int unsigned last;
        int unsigned w;
        string       tag;
        last = v.sn + v.ln;
        if (v.sd + v.ld > last) last = v.sd + v.ld;
        if (v.sq + v.lq > last) last = v.sq + v.lq;
        w   = last + 14;
        tag = $sformatf("vec%0d", idx);
        clear_rec();
        en = v.en;
        drive_vec(v, 1);
        for (int unsigned e = 1; e <= w; e++) begin
            @(posedge clk);
            #1;
            sample_rec(e);
            drive_vec(v, e + 1);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            expect_out(tag, 0, k, v.e1[k]);
            expect_out(tag, 1, k, v.e3[k]);
        end
        check({tag, "_busy_dut1"}, rec_busy[0], v.bz1);
        check({tag, "_busy_dut3"}, rec_busy[1], v.bz3);
    endtask

    initial begin
        bit [2:0]    rv;
        int unsigned rem[3];

        tbl[0] = '{0,0, 1,10, 0,0,  1'b1, '{0,7,0,0}, 1, '{0,7,0,0}, 3};   // clean dime
        tbl[1] = '{1,3, 0,0,  0,0,  1'b1, '{0,0,0,0}, 0, '{0,0,0,0}, 0};   // 3-cycle glitch
        tbl[2] = '{0,0, 1,8,  1,8,  1'b1, '{0,0,0,7}, 0, '{0,0,0,7}, 0};   // dime+quarter together
        tbl[3] = '{0,0, 0,0,  1,8,  1'b0, '{0,0,0,7}, 0, '{0,0,0,7}, 0};   // disabled
        tbl[4] = '{0,0, 0,0,  1,8,  1'b1, '{0,0,7,0}, 1, '{0,0,7,0}, 3};   // enabled
        tbl[5] = '{1,4, 0,0,  0,0,  1'b1, '{7,0,0,0}, 1, '{7,0,0,0}, 3};   // minimum accepted width
        tbl[6] = '{0,0, 0,0,  1,40, 1'b1, '{0,0,7,0}, 1, '{0,0,7,0}, 3};   // held high long
        tbl[7] = '{1,6, 1,6,  1,6,  1'b1, '{0,0,0,7}, 0, '{0,0,0,7}, 0};   // all three
        tbl[8] = '{1,6, 3,6,  0,0,  1'b1, '{7,9,0,0}, 2, '{7,0,0,9}, 3};   // dime 2 after N
        tbl[9] = '{1,6, 6,6,  0,0,  1'b1, '{7,12,0,0}, 2, '{7,12,0,0}, 6}; // dime 5 after N

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {b3, rj3, q3, d3, n3, b1, rj1, q1, d1, n1}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        for (int unsigned t = 0; t < 10; t++) run_vec(t, tbl[t]);

        // Bounce: 1,0,1,0 then held for 8 edges; final rise at edge 5.
        clear_rec();
        en = 1'b1;
        rn = 1'b1;
        for (int unsigned e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            sample_rec(e);
            rn = (e + 1 <= 4) ? ((e + 1) % 2 == 1) : (e + 1 <= 12);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            expect_out("bounce", 0, k, (k == 0) ? 11 : 0);
            expect_out("bounce", 1, k, (k == 0) ? 11 : 0);
        end

        // Reset in the middle of a quarter's debounce, sensor still high after release.
        rq = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_debounce_outs", {b3, rj3, q3, d3, n3, b1, rj1, q1, d1, n1}, 0);
        @(negedge clk) rst_n = 1'b1;
        clear_rec();
        for (int unsigned e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            sample_rec(e);
            if (e == 10) rq = 1'b0;
        end
        for (int unsigned k = 0; k < 4; k++) begin
            expect_out("rst_release", 0, k, (k == 2) ? 7 : 0);
            expect_out("rst_release", 1, k, (k == 2) ? 7 : 0);
        end

        // Reset while a dime pulse and hold-off are active.
        rd = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("pre_rst_dime_pulse", {d3, b3, d1, b1}, 4'b1111);
        rst_n = 1'b0;
        #1;
        check("rst_mid_hold_outs", {b3, rj3, q3, d3, n3, b1, rj1, q1, d1, n1}, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        clear_rec();
        for (int unsigned e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            sample_rec(e);
        end
        for (int unsigned k = 0; k < 4; k++) begin
            expect_out("post_rst", 0, k, 0);
            expect_out("post_rst", 1, k, 0);
        end

        // Random sensor activity, enable toggling and occasional resets.
        en = 1'b1;
        rv = '0;
        for (int unsigned l = 0; l < 3; l++) rem[l] = $urandom_range(0, 8);
        for (int unsigned c = 0; c < 2500; c++) begin
            @(posedge clk);
            #1;
            for (int unsigned l = 0; l < 3; l++) begin
                if (rem[l] == 0) begin
                    rv[l]  = ~rv[l];
                    rem[l] = rv[l] ? $urandom_range(1, 10) : $urandom_range(1, 14);
                end else begin
                    rem[l]--;
                end
            end
            {rq, rd, rn} = rv;
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end

        {rq, rd, rn} = 3'b000;
        repeat (20) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/coin_pulse_gen.md
Name: coin_pulse_gen

Overview:
Front-end coin acceptor stage that feeds the newspaper vending FSM.
- Takes three raw, asynchronous, bouncy coin-sensor lines (nickel, dime, quarter) and turns them into clean single-cycle, mutually exclusive N/D/Q pulses in the clk domain.
- Accepts at most one coin per pulse slot. Coins arriving together, while disabled, or inside the hold-off window are flagged as rejected.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples at the new level required before the debounced level changes (min 1)
HOLDOFF_CYCLES, 1, idle cycles forced after each accepted pulse before another coin is accepted (0 = none)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_n_raw  in  1  nickel sensor, active high, asynchronous, may bounce
coin_d_raw  in  1  dime sensor, active high, asynchronous, may bounce
coin_q_raw  in  1  quarter sensor, active high, asynchronous, may bounce
enable  in  1  downstream vending FSM ready to take coins
N  out  1  one-cycle nickel pulse to the vending FSM
D  out  1  one-cycle dime pulse to the vending FSM
Q  out  1  one-cycle quarter pulse to the vending FSM
reject  out  1  one-cycle pulse: detected coin was not accepted (drives the return-chute gate)
busy  out  1  high while in hold-off

Behaviour:
- Reset (rst_n low, asynchronous): all sync flops, debounced levels, counters and outputs go to 0; FSM goes to IDLE. Reset mid-debounce or mid-hold-off discards all progress.
- Synchronizer: 2-flop synchronizer per raw line; sync2 is the second-flop output.
- Debounce, per line, with a counter sized for DEBOUNCE_CYCLES-1:
  - if sync2 equals the stable level, the counter clears;
  - otherwise the counter increments;
  - the stable level takes sync2 (and the counter clears) on the DEBOUNCE_CYCLES-th consecutive differing sample.
- Edge detect: a coin event for a line is the cycle in which its stable level is 1 and its delayed copy is 0. Falling edges produce no output.
- Latency: number the first clk edge that samples raw=1 as edge 1. Stable rises at edge DEBOUNCE_CYCLES+2. The output pulse is high from edge DEBOUNCE_CYCLES+3 to edge DEBOUNCE_CYCLES+4. With default parameters, N/D/Q goes high at edge 7 for exactly one cycle.
- Raw pulse handling:
  - A raw pulse held high for fewer than DEBOUNCE_CYCLES synchronized samples produces nothing.
  - A coin held high indefinitely produces exactly one pulse.
- FSM states: IDLE, HOLD.
  - IDLE, exactly one event, enable=1: register the matching N/D/Q high for one cycle. Go to HOLD with hold counter = HOLDOFF_CYCLES, or stay in IDLE if HOLDOFF_CYCLES=0.
  - IDLE, two or more events in the same cycle: reject=1 for one cycle, no N/D/Q, stay in IDLE.
  - IDLE, any event with enable=0: reject=1 for one cycle, no N/D/Q.
  - HOLD: the counter decrements each cycle and returns to IDLE when it reaches 0. Any event during HOLD gives reject=1 and does not extend HOLD.
- Outputs are registered. N, D and Q are never simultaneously high. reject and N/D/Q are never high in the same cycle.
- busy = (state == HOLD).
- With default HOLDOFF_CYCLES=1, consecutive accepted pulses are separated by at least one low cycle, which matches the vending FSM's expectation of a 000 cycle between coins.

Test Plan:
- Clean dime: coin_d_raw high for 10 cycles, enable=1 -> D high for exactly one cycle at edge 7; N, Q, reject stay 0; busy high for 1 cycle after D.
- Bounce: coin_n_raw toggles 1,0,1,0 at one-cycle intervals, then holds 1 for 8 cycles -> exactly one N pulse, 7 edges after the final rise; short glitches (3 cycles high) alone -> no output.
- Simultaneous: coin_d_raw and coin_q_raw rise on the same edge, 8 cycles each -> reject one cycle at edge 7; D=Q=0.
- Disabled: enable=0, coin_q_raw held 8 cycles -> reject one cycle, Q=0. Repeat with enable=1 -> Q one cycle.
- Hold-off: HOLDOFF_CYCLES=3; nickel accepted, then a dime whose event lands 2 cycles after the N pulse -> reject, no D; a dime event 5 cycles after N -> D accepted.
- Async reset: assert rst_n=0 mid-debounce (edge 4 of a quarter) -> all outputs 0 immediately; release with coin_q_raw still high -> one Q pulse 7 edges after release.
